// File: rtl/timer_ctrl_pkg.sv
// Shared types and constants for the microwave countdown sequencer.
// Imported by the control FSM, its prescaler and the bus interface.
package timer_ctrl_pkg;

  localparam int unsigned BCD_W        = 4;
  localparam int unsigned ENTRY_W      = 4 * BCD_W;
  localparam logic [ENTRY_W-1:0] QUICK_START = 16'h0030;
  localparam logic [BCD_W-1:0]   MAX_SEC_TENS = 4'd5;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTRY   = 3'd1,
    LOAD    = 3'd2,
    RUNNING = 3'd3,
    PAUSED  = 3'd4,
    DONE    = 3'd5
  } state_e;

  // Keypad codes above 9 are not digits and must be dropped.
  function automatic logic digit_ok(input logic [BCD_W-1:0] d);
    return d <= 4'd9;
  endfunction

endpackage

// File: rtl/timer_ctrl_if.sv
// Keypad/control inputs and counter-chain outputs of the countdown sequencer.
interface timer_ctrl_if;
  import timer_ctrl_pkg::*;

  logic               key_valid;
  logic [BCD_W-1:0]   key_digit;
  logic               start;
  logic               stop;
  logic               door_open;
  logic               cnt_zero;
  logic               loadn;
  logic [ENTRY_W-1:0] load_data;
  logic               cnt_en;
  logic               mag_on;
  logic               done;
  logic               err;

  modport master (
    output key_valid, key_digit, start, stop, door_open, cnt_zero,
    input  loadn, load_data, cnt_en, mag_on, done, err
  );

  modport slave (
    input  key_valid, key_digit, start, stop, door_open, cnt_zero,
    output loadn, load_data, cnt_en, mag_on, done, err
  );

endinterface

// File: rtl/timer_ctrl_tick_gen.sv
// Prescaler counting 0..TICK_DIV-1; tick_o marks the last count of each period.
module timer_ctrl_tick_gen #(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic clrn,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned     CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count_q;

  // NOTE: sequential state is written with <= only so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= (count_q == LAST) ? '0 : count_q + CNT_W'(1);
    end
  end

  assign tick_o = en_i && !clr_i && (count_q == LAST);

endmodule

// File: rtl/timer_ctrl.sv
// Microwave MM:SS sequencer: keypad entry, chain load, 1 Hz count enable,
// pause on door/stop and timed completion indicator. All outputs registered.
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 100_000_000,
  parameter int unsigned DONE_TICKS = 3
) (
  input  logic         clk,
  input  logic         clrn,
  timer_ctrl_if.slave  bus
);

  localparam int unsigned      DC_W      = (DONE_TICKS > 1) ? $clog2(DONE_TICKS) : 1;
  localparam logic [DC_W-1:0]  DONE_LAST = DC_W'(DONE_TICKS - 1);

  state_e             state_q;
  logic [ENTRY_W-1:0] entry_q;
  logic [ENTRY_W-1:0] load_data_q;
  logic [DC_W-1:0]    done_cnt_q;
  logic               loadn_q, cnt_en_q, mag_on_q, done_q, err_q;

  logic presc_en, tick, key_ok, start_bad;

  // Prescaler only runs while counting or timing out DONE, so it restarts at 0 on each RUNNING entry.
  assign presc_en  = (state_q == RUNNING) || (state_q == DONE);
  assign key_ok    = bus.key_valid && digit_ok(bus.key_digit);
  assign start_bad = (entry_q == '0) || (entry_q[7:4] > MAX_SEC_TENS);

  timer_ctrl_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk    (clk),
    .clrn   (clrn),
    .clr_i  (!presc_en),
    .en_i   (presc_en),
    .tick_o (tick)
  );

  // NOTE: the entry register is a plain register, not a memory, so it takes the async reset too.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q     <= IDLE;
      entry_q     <= '0;
      load_data_q <= '0;
      done_cnt_q  <= '0;
      loadn_q     <= 1'b1;
      cnt_en_q    <= 1'b0;
      mag_on_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      // NOTE: strobes default to idle each cycle so no branch can leave them stuck.
      loadn_q  <= 1'b1;
      cnt_en_q <= 1'b0;
      err_q    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.stop) begin
            entry_q <= '0;
          end else if (bus.start) begin
            if (!bus.door_open) begin
              entry_q     <= QUICK_START;
              load_data_q <= QUICK_START;
              loadn_q     <= 1'b0;
              state_q     <= LOAD;
            end
          end else if (key_ok) begin
            entry_q <= {12'h000, bus.key_digit};
            state_q <= ENTRY;
          end
        end
        ENTRY: begin
          if (bus.stop) begin
            entry_q <= '0;
            state_q <= IDLE;
          end else if (bus.start) begin
            if (!bus.door_open) begin
              if (start_bad) begin
                err_q <= 1'b1;
              end else begin
                load_data_q <= entry_q;
                loadn_q     <= 1'b0;
                state_q     <= LOAD;
              end
            end
          end else if (key_ok) begin
            entry_q <= {entry_q[11:0], bus.key_digit};
          end
        end
        LOAD: begin
          mag_on_q <= 1'b1;
          state_q  <= RUNNING;
        end
        RUNNING: begin
          if (bus.stop || bus.door_open) begin
            mag_on_q <= 1'b0;
            state_q  <= PAUSED;
          end else if (bus.cnt_zero) begin
            mag_on_q   <= 1'b0;
            done_q     <= 1'b1;
            done_cnt_q <= '0;
            state_q    <= DONE;
          end else if (tick) begin
            cnt_en_q <= 1'b1;
          end
        end
        PAUSED: begin
          if (bus.stop) begin
            entry_q <= '0;
            state_q <= IDLE;
          end else if (bus.start && !bus.door_open) begin
            mag_on_q <= 1'b1;
            state_q  <= RUNNING;
          end
        end
        DONE: begin
          if (bus.stop || bus.door_open || bus.start || bus.key_valid) begin
            done_q  <= 1'b0;
            state_q <= IDLE;
          end else if (tick) begin
            if (done_cnt_q == DONE_LAST) begin
              done_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              done_cnt_q <= done_cnt_q + DC_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.loadn     = loadn_q;
  assign bus.load_data = load_data_q;
  assign bus.cnt_en    = cnt_en_q;
  assign bus.mag_on    = mag_on_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl with TICK_DIV=4, DONE_TICKS=3 and an MM:SS mod6/mod10 chain model.
module tb_timer_ctrl;
  import timer_ctrl_pkg::*;

  localparam int unsigned TICK_DIV   = 4;
  localparam int unsigned DONE_TICKS = 3;

  logic clk;
  logic clrn;
  timer_ctrl_if tif ();

  timer_ctrl #(.TICK_DIV(TICK_DIV), .DONE_TICKS(DONE_TICKS)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (tif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counter chain: min_tens mod6, min_units mod10, sec_tens mod6, sec_units mod10.
  logic [3:0] mt, mu, st, su;
  logic [15:0] chain;
  assign chain        = {mt, mu, st, su};
  assign tif.cnt_zero = (chain == 16'h0000);

  always @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      {mt, mu, st, su} <= 16'h0000;
    end else if (!tif.loadn) begin
      {mt, mu, st, su} <= tif.load_data;
    end else if (tif.cnt_en) begin
      su <= (su == 0) ? 4'd9 : su - 4'd1;
      if (su == 0) begin
        st <= (st == 0) ? 4'd5 : st - 4'd1;
        if (st == 0) begin
          mu <= (mu == 0) ? 4'd9 : mu - 4'd1;
          if (mu == 0) mt <= (mt == 0) ? 4'd5 : mt - 4'd1;
        end
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int wrap_cnt = 0;

  always @(negedge clk) if (clrn && tif.cnt_en && tif.cnt_zero) wrap_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    tif.key_valid = 1'b0;
    tif.key_digit = 4'd0;
    tif.start     = 1'b0;
    tif.stop      = 1'b0;
    tif.door_open = 1'b0;
  endtask

  task automatic reset_dut();
    idle_inputs();
    clrn = 1'b0;
    step();
    step();
    clrn = 1'b1;
    step();
  endtask

  task automatic press(input logic [3:0] d);
    tif.key_valid = 1'b1;
    tif.key_digit = d;
    step();
    tif.key_valid = 1'b0;
  endtask

  task automatic pulse_start();
    tif.start = 1'b1;
    step();
    tif.start = 1'b0;
  endtask

  function automatic int to_sec(input logic [15:0] v);
    return int'(v[15:12]) * 600 + int'(v[11:8]) * 60 + int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  typedef struct {
    logic        kv;
    logic [3:0]  dig;
    logic        st;
    logic        sp;
    logic        door;
    logic        e_loadn;
    logic        e_err;
    logic        e_mag;
    logic [15:0] e_ld;
    logic [15:0] e_entry;
    state_e      e_state;
  } vec_t;

  vec_t vecs[22];

  initial begin
    int pulses, last, min_gap, max_gap, cyc, width, first_en, lows;
    logic [15:0] held;

    //          kv  dig    st  sp  door loadn err mag load_data entry     state
    vecs[0]  = '{1, 4'd1,  0,  0,  0,   1,    0,  0,  16'h0000, 16'h0001, ENTRY};
    vecs[1]  = '{1, 4'd2,  0,  0,  0,   1,    0,  0,  16'h0000, 16'h0012, ENTRY};
    vecs[2]  = '{1, 4'd3,  0,  0,  0,   1,    0,  0,  16'h0000, 16'h0123, ENTRY};
    vecs[3]  = '{1, 4'd4,  0,  0,  0,   1,    0,  0,  16'h0000, 16'h1234, ENTRY};
    vecs[4]  = '{1, 4'd5,  0,  0,  0,   1,    0,  0,  16'h0000, 16'h2345, ENTRY};
    vecs[5]  = '{1, 4'd12, 0,  0,  0,   1,    0,  0,  16'h0000, 16'h2345, ENTRY};
    vecs[6]  = '{1, 4'd0,  0,  0,  0,   1,    0,  0,  16'h0000, 16'h3450, ENTRY};
    vecs[7]  = '{1, 4'd0,  0,  0,  0,   1,    0,  0,  16'h0000, 16'h4500, ENTRY};
    vecs[8]  = '{1, 4'd7,  0,  0,  0,   1,    0,  0,  16'h0000, 16'h5007, ENTRY};
    vecs[9]  = '{1, 4'd5,  0,  0,  0,   1,    0,  0,  16'h0000, 16'h0075, ENTRY};
    vecs[10] = '{0, 4'd0,  1,  0,  0,   1,    1,  0,  16'h0000, 16'h0075, ENTRY};
    vecs[11] = '{0, 4'd0,  0,  0,  0,   1,    0,  0,  16'h0000, 16'h0075, ENTRY};
    vecs[12] = '{1, 4'd3,  1,  0,  0,   1,    1,  0,  16'h0000, 16'h0075, ENTRY};
    vecs[13] = '{0, 4'd0,  0,  1,  0,   1,    0,  0,  16'h0000, 16'h0000, IDLE};
    vecs[14] = '{0, 4'd0,  1,  1,  0,   1,    0,  0,  16'h0000, 16'h0000, IDLE};
    vecs[15] = '{0, 4'd0,  1,  0,  0,   0,    0,  0,  16'h0030, 16'h0030, LOAD};
    vecs[16] = '{0, 4'd0,  0,  0,  0,   1,    0,  1,  16'h0030, 16'h0030, RUNNING};
    vecs[17] = '{0, 4'd0,  0,  1,  0,   1,    0,  0,  16'h0030, 16'h0030, PAUSED};
    vecs[18] = '{0, 4'd0,  1,  1,  0,   1,    0,  0,  16'h0030, 16'h0000, IDLE};
    vecs[19] = '{1, 4'd0,  0,  0,  0,   1,    0,  0,  16'h0030, 16'h0000, ENTRY};
    vecs[20] = '{0, 4'd0,  1,  0,  0,   1,    1,  0,  16'h0030, 16'h0000, ENTRY};
    vecs[21] = '{0, 4'd0,  0,  1,  0,   1,    0,  0,  16'h0030, 16'h0000, IDLE};

    // Reset values
    reset_dut();
    check("rst loadn", 32'(tif.loadn), 32'd1);
    check("rst load_data", 32'(tif.load_data), 32'h0);
    check("rst cnt_en", 32'(tif.cnt_en), 32'd0);
    check("rst mag_on", 32'(tif.mag_on), 32'd0);
    check("rst done", 32'(tif.done), 32'd0);
    check("rst err", 32'(tif.err), 32'd0);
    check("rst state", 32'(dut.state_q), 32'(IDLE));

    // Entry, rejected starts, quick start, pause and clear
    for (int i = 0; i < 22; i++) begin
      tif.key_valid = vecs[i].kv;
      tif.key_digit = vecs[i].dig;
      tif.start     = vecs[i].st;
      tif.stop      = vecs[i].sp;
      tif.door_open = vecs[i].door;
      step();
      idle_inputs();
      check($sformatf("vec%0d loadn", i), 32'(tif.loadn), 32'(vecs[i].e_loadn));
      check($sformatf("vec%0d err", i), 32'(tif.err), 32'(vecs[i].e_err));
      check($sformatf("vec%0d mag_on", i), 32'(tif.mag_on), 32'(vecs[i].e_mag));
      check($sformatf("vec%0d load_data", i), 32'(tif.load_data), 32'(vecs[i].e_ld));
      check($sformatf("vec%0d entry", i), 32'(dut.entry_q), 32'(vecs[i].e_entry));
      check($sformatf("vec%0d state", i), 32'(dut.state_q), 32'(vecs[i].e_state));
    end

    // Full 1:23 countdown to completion
    reset_dut();
    press(4'd1); press(4'd2); press(4'd3);
    pulse_start();
    check("t1 loadn low", 32'(tif.loadn), 32'd0);
    check("t1 load_data", 32'(tif.load_data), 32'h0123);
    step();
    check("t1 loadn release", 32'(tif.loadn), 32'd1);
    check("t1 mag_on", 32'(tif.mag_on), 32'd1);
    check("t1 chain loaded", 32'(chain), 32'h0123);
    pulses = 0; last = -1; min_gap = 1000; max_gap = 0; cyc = 0;
    while (!tif.done && cyc < 2000) begin
      step();
      cyc++;
      if (tif.cnt_en) begin
        if (last >= 0) begin
          if (cyc - last < min_gap) min_gap = cyc - last;
          if (cyc - last > max_gap) max_gap = cyc - last;
        end
        last = cyc;
        pulses++;
      end
    end
    check("t1 done reached", 32'(tif.done), 32'd1);
    check("t1 tick count", 32'(pulses), 32'd83);
    check("t1 min gap", 32'(min_gap), 32'(TICK_DIV));
    check("t1 max gap", 32'(max_gap), 32'(TICK_DIV));
    check("t1 chain zero", 32'(chain), 32'h0);
    check("t1 mag_on at done", 32'(tif.mag_on), 32'd0);
    width = 0;
    while (tif.done && width < 100) begin
      width++;
      step();
    end
    // Last decrement lands 2 counts before the prescaler wraps, so DONE lasts 2 + (DONE_TICKS-1)*TICK_DIV.
    check("t1 done width", 32'(width), 32'(2 + (DONE_TICKS - 1) * TICK_DIV));
    check("t1 state idle", 32'(dut.state_q), 32'(IDLE));
    check("t1 mag_on off", 32'(tif.mag_on), 32'd0);

    // Door open mid-run, start while open, resume
    reset_dut();
    press(4'd2); press(4'd0);
    pulse_start();
    step();
    repeat (10) step();
    tif.door_open = 1'b1;
    step();
    check("t4 mag_on off", 32'(tif.mag_on), 32'd0);
    check("t4 cnt_en off", 32'(tif.cnt_en), 32'd0);
    held = chain;
    pulses = 0;
    repeat (12) begin
      step();
      if (tif.cnt_en) pulses++;
    end
    check("t4 no ticks paused", 32'(pulses), 32'd0);
    check("t4 chain held", 32'(chain), 32'(held));
    pulse_start();
    check("t4 start while open", 32'(tif.mag_on), 32'd0);
    check("t4 still paused", 32'(dut.state_q), 32'(PAUSED));
    tif.door_open = 1'b0;
    step();
    pulse_start();
    check("t4 resume mag_on", 32'(tif.mag_on), 32'd1);
    check("t4 resume state", 32'(dut.state_q), 32'(RUNNING));
    first_en = -1; lows = 0;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (!tif.loadn) lows++;
      if (tif.cnt_en && first_en < 0) first_en = i;
    end
    check("t4 no reload", 32'(lows), 32'd0);
    check("t4 first tick", 32'(first_en), 32'(TICK_DIV));
    check("t4 chain resumed", 32'(to_sec(chain)), 32'(to_sec(held) - 1));

    // Key during DONE returns to IDLE immediately
    reset_dut();
    press(4'd1);
    pulse_start();
    cyc = 0;
    while (!tif.done && cyc < 200) begin
      step();
      cyc++;
    end
    check("t5 done reached", 32'(tif.done), 32'd1);
    press(4'd3);
    check("t5 done cleared", 32'(tif.done), 32'd0);
    check("t5 state idle", 32'(dut.state_q), 32'(IDLE));

    // Asynchronous reset mid-run
    reset_dut();
    pulse_start();
    repeat (9) step();
    check("t6 running", 32'(tif.mag_on), 32'd1);
    #2 clrn = 1'b0;
    #1;
    check("t6 loadn", 32'(tif.loadn), 32'd1);
    check("t6 load_data", 32'(tif.load_data), 32'h0);
    check("t6 cnt_en", 32'(tif.cnt_en), 32'd0);
    check("t6 mag_on", 32'(tif.mag_on), 32'd0);
    check("t6 done", 32'(tif.done), 32'd0);
    check("t6 err", 32'(tif.err), 32'd0);
    check("t6 state", 32'(dut.state_q), 32'(IDLE));
    check("t6 chain", 32'(chain), 32'h0);
    step();
    clrn = 1'b1;
    step();

    check("no wrap past zero", 32'(wrap_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
